road_scroll_overlay: RTL
========================

# road_scroll_overlay

Pixel-pipeline stage directly downstream of the track colour generator. It takes the registered 12-bit track colour for the current pixel and overlays scrolling dashed lane markers, producing the final road-layer colour for the sprite/car compositor. A per-frame scroll counter creates the illusion of forward motion. The counter advances faster at higher levels and freezes while paused.

## Interface
Parameters:
- LANE1_COL, 254: first column of left lane marker (marker is 4 px wide).
- LANE2_COL, 383: first column of right lane marker (4 px wide).
- DASH_LOG2, 6: log2 of dash period in rows; dash is lit for the first half of the period.
- FRAME_ROW, 480: row value whose first appearance marks start of vertical blank.

Ports:
- clk, in, 1: pixel clock, all logic on rising edge.
- reset, in, 1: synchronous, active-high.
- pix_row, in, 10: current pixel row from dtg.
- pix_col, in, 10: current pixel column from dtg.
- video_on, in, 1: dtg display-enable for the current pixel.
- track_color_in, in, 12: track colour. Valid one cycle after the matching pix_row/pix_col.
- level, in, 2: game level. Selects scroll speed.
- pause, in, 1: freezes scrolling when high.
- pix_color_out, out, 12: overlaid colour, {R[11:8],G[7:4],B[3:0]}.
- scroll_offset, out, DASH_LOG2: current scroll offset, for obstacle logic alignment.

## Operation
- Stage 1 (registered): delay pix_row, pix_col and video_on by one cycle. This aligns them with track_color_in.
- Stage 2 (registered): compute pix_color_out from the delayed coordinates, track_color_in and scroll_offset.
  - If delayed video_on = 0 → 12'h000.
  - Else if delayed col ∈ [LANE1_COL, LANE1_COL+3] or [LANE2_COL, LANE2_COL+3], delayed row ≤ 479, and ((row − scroll_offset) mod 2^DASH_LOG2) < 2^(DASH_LOG2−1) → 12'hFFF.
  - Else → track_color_in.
- Row subtraction is DASH_LOG2 bits wide and wraps. The result is that dashes move down the screen as the offset increases.
- Frame tick: a one-cycle internal pulse when pix_row == FRAME_ROW and the registered previous-row-was-FRAME_ROW flag is 0.
- Scroll update on a frame tick:
  - If pause = 0: scroll_offset ← scroll_offset + (level + 1). Speed is 1, 2, 3 or 4 px/frame. The sum wraps modulo 2^DASH_LOG2.
  - If pause = 1: scroll_offset holds.
- level and pause are sampled only on the tick cycle. Changes mid-frame take effect at the next tick, so the image never tears mid-frame.

## Timing
- Latency is 2 cycles from pix_row/pix_col/video_on to pix_color_out. It is 1 cycle from track_color_in.
- scroll_offset changes only in the cycle after a frame tick. That is during vertical blank, never while visible rows are drawn.
- Reset values:
  - pix_color_out = 0.
  - scroll_offset = 0.
  - Stage-1 registers = 0.
  - Previous-row flag = 1, so no tick occurs if reset is released while pix_row == FRAME_ROW.
- Reset mid-frame: outputs are black from the reset cycle until 2 cycles after release. The offset restarts at 0. The first tick is the next fresh entry into FRAME_ROW.
- Reset asserted on a tick cycle: reset wins, and the offset becomes 0.
- Wrap: with DASH_LOG2 = 6 and offset 62, a level-3 tick gives 2.

## Configuration
- ROAD_SCROLL_CURB_EN defined:
  - Border columns 126–129 and 511–514, for rows ≤ 479 with video on, become scrolling curbs.
  - Curb colour is 12'hF00 when bit 4 of (row − scroll_offset) = 0, and 12'hFFF otherwise.
  - Curb takes priority over track_color_in. Lane markers are unaffected.
- Not defined: border columns pass track_color_in unchanged. No curb logic is synthesised.

## Test plan
- Reset, then drive video_on = 1, col = 254, row = 0, track_color_in = 12'h999 → pix_color_out = 12'hFFF two cycles after the coordinates; 12'h999 at col = 300.
- Offset 0, col = 254, row = 32 → 12'h999 (gap). After 8 level-3 frame ticks the offset is 32 → row 32 gives 12'hFFF.
- level = 2 with pix_row stepping 479→480, held at 480 for 800 cycles → exactly one tick, and scroll_offset goes 0→3.
- pause = 1 across 3 frames → scroll_offset unchanged. pause = 0 → it resumes at the next tick.
- Offset 62, level = 3, tick → scroll_offset = 2.
- Reset released while pix_row = 480 → no tick until the row leaves 480 and returns. With ROAD_SCROLL_CURB_EN defined, col = 127, row = 0, offset 0 → 12'hF00; row 16 → 12'hFFF.

Source files
------------

// File: rtl/road_scroll_overlay.sv
// road_scroll_overlay: overlays scrolling dashed lane markers on the registered
// track colour. Two registered stages (coordinate delay, colour select) plus a
// per-frame scroll counter advanced once per vertical blank.
// Optional feature macro: ROAD_SCROLL_CURB_EN (scrolling red/white border curbs).
module road_scroll_overlay #(
  parameter int LANE1_COL = 254,
  parameter int LANE2_COL = 383,
  parameter int DASH_LOG2 = 6,
  parameter int FRAME_ROW = 480
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [9:0]           pix_row,
  input  logic [9:0]           pix_col,
  input  logic                 video_on,
  input  logic [11:0]          track_color_in,
  input  logic [1:0]           level,
  input  logic                 pause,
  output logic [11:0]          pix_color_out,
  output logic [DASH_LOG2-1:0] scroll_offset
);

  localparam logic [9:0] L1_LO    = 10'(LANE1_COL);
  localparam logic [9:0] L1_HI    = 10'(LANE1_COL + 3);
  localparam logic [9:0] L2_LO    = 10'(LANE2_COL);
  localparam logic [9:0] L2_HI    = 10'(LANE2_COL + 3);
  localparam logic [9:0] LAST_VIS = 10'd479;
  localparam logic [9:0] FRM      = 10'(FRAME_ROW);

  logic [9:0]           row_d, col_d;
  logic                 von_d;
  logic                 prev_frame;
  logic                 tick;
  logic [DASH_LOG2-1:0] diff;
  logic                 visible, on_lane, dash_lit;
  logic [11:0]          color_nxt;

  // Tick only on the first cycle of FRAME_ROW; reset parks the flag high so a
  // release in the middle of FRAME_ROW cannot fire a spurious tick.
  assign tick = (pix_row == FRM) && !prev_frame;

  // Stage 1: align coordinates with track_color_in, which arrives a cycle late.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_d <= '0;
      col_d <= '0;
      von_d <= 1'b0;
    end else begin
      row_d <= pix_row;
      col_d <= pix_col;
      von_d <= video_on;
    end
  end

  // Frame-tick edge detector and scroll counter; level/pause only matter on the tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_frame    <= 1'b1;
      scroll_offset <= '0;
    end else begin
      prev_frame <= (pix_row == FRM);
      if (tick && !pause)
        scroll_offset <= scroll_offset + DASH_LOG2'(level) + DASH_LOG2'(1);
    end
  end

  // Wrapping row-minus-offset: dash lit in the first half of each period.
  assign diff     = row_d[DASH_LOG2-1:0] - scroll_offset;
  assign dash_lit = ~diff[DASH_LOG2-1];
  assign visible  = (row_d <= LAST_VIS);
  assign on_lane  = ((col_d >= L1_LO) && (col_d <= L1_HI)) ||
                    ((col_d >= L2_LO) && (col_d <= L2_HI));

`ifdef ROAD_SCROLL_CURB_EN
  logic on_curb;
  assign on_curb = ((col_d >= 10'd126) && (col_d <= 10'd129)) ||
                   ((col_d >= 10'd511) && (col_d <= 10'd514));
`endif

  // Stage 2 colour select: blank, lane dash, optional curb, else track colour.
  always_comb begin
    color_nxt = track_color_in;
    if (!von_d)
      color_nxt = 12'h000;
    else if (on_lane && visible && dash_lit)
      color_nxt = 12'hFFF;
`ifdef ROAD_SCROLL_CURB_EN
    else if (on_curb && visible)
      color_nxt = diff[4] ? 12'hFFF : 12'hF00;
`endif
  end

  // Stage 2 output register.
  always_ff @(posedge clk) begin
    if (reset) pix_color_out <= 12'h000;
    else       pix_color_out <= color_nxt;
  end

endmodule
